// File: rtl/stpu_irom_arbiter.sv
`default_nettype none
// stpu_irom_arbiter: shares the 1-cycle-latency instruction ROM between CPU fetch and debug reads.
// Fixed CPU priority with debug starvation guard; define STPU_IROM_ARB_RR_EN for round-robin. Rev 1.0
module stpu_irom_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    owner_t            r_owner;
    logic [ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              w_cpu_gnt;
    logic              w_dbg_gnt;
    logic              w_tie_dbg;
    logic [ADDR_W-1:0] w_rom_addr;

`ifdef STPU_IROM_ARB_RR_EN
    logic r_last_dbg;

    assign w_tie_dbg = ~r_last_dbg;
`else
    localparam logic [7:0] c_starve_max = 8'(STARVE_MAX);

    logic [7:0] r_starve_cnt;

    assign w_tie_dbg = (r_starve_cnt == c_starve_max);
`endif

    // Grants are forced low while reset is held so nothing is issued to the ROM.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        if (rst) begin
            if (cpu_req_i && dbg_req_i) begin
                w_dbg_gnt = w_tie_dbg;
                w_cpu_gnt = ~w_tie_dbg;
            end else begin
                w_cpu_gnt = cpu_req_i;
                w_dbg_gnt = dbg_req_i;
            end
        end
    end

    // Without a grant the address is held so the ROM output stays put.
    assign w_rom_addr = w_cpu_gnt ? cpu_addr_i :
                        w_dbg_gnt ? dbg_addr_i : r_last_addr;

    assign cpu_gnt_o    = w_cpu_gnt;
    assign dbg_gnt_o    = w_dbg_gnt;
    assign rom_ce_o     = w_cpu_gnt | w_dbg_gnt;
    assign rom_addr_o   = w_rom_addr;
    assign cpu_rvalid_o = (r_owner == OWN_CPU);
    assign dbg_rvalid_o = (r_owner == OWN_DBG);
    assign cpu_rdata_o  = cpu_rvalid_o ? rom_data_i : r_cpu_rdata;
    assign dbg_rdata_o  = dbg_rvalid_o ? rom_data_i : r_dbg_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner     <= OWN_NONE;
            r_last_addr <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (w_cpu_gnt) begin
                r_owner <= OWN_CPU;
            end else if (w_dbg_gnt) begin
                r_owner <= OWN_DBG;
            end else begin
                r_owner <= OWN_NONE;
            end
            if (w_cpu_gnt || w_dbg_gnt) begin
                r_last_addr <= w_rom_addr;
            end
            if (r_owner == OWN_CPU) begin
                r_cpu_rdata <= rom_data_i;
            end
            if (r_owner == OWN_DBG) begin
                r_dbg_rdata <= rom_data_i;
            end
        end
    end

`ifdef STPU_IROM_ARB_RR_EN
    // Resets to "debug last" so the CPU takes the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_dbg <= 1'b1;
        end else if (w_cpu_gnt) begin
            r_last_dbg <= 1'b0;
        end else if (w_dbg_gnt) begin
            r_last_dbg <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (dbg_req_i && !w_dbg_gnt) begin
            if (r_starve_cnt != 8'hFF) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stpu_irom_arbiter.sv
`default_nettype none
// tb_stpu_irom_arbiter: randomized self-checking bench with a cycle-level arbitration/ROM model.
// Follows STPU_IROM_ARB_RR_EN to select the expected arbitration policy. Rev 1.0
module tb_stpu_irom_arbiter;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_req_i = 1'b0;
    logic [ADDR_W-1:0] cpu_addr_i = '0;
    logic              cpu_gnt_o;
    logic              cpu_rvalid_o;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              dbg_req_i = 1'b0;
    logic [ADDR_W-1:0] dbg_addr_i = '0;
    logic              dbg_gnt_o;
    logic              dbg_rvalid_o;
    logic [DATA_W-1:0] dbg_rdata_o;
    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_spo = '0;

    logic [DATA_W-1:0] rom_mem [32];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    int                m_pend;       // 0 none, 1 cpu, 2 dbg
    logic [ADDR_W-1:0] m_pend_addr;
    logic [ADDR_W-1:0] m_last_addr;
    logic [DATA_W-1:0] m_cpu_word;
    logic [DATA_W-1:0] m_dbg_word;
    int                m_denied;
    int                m_last_winner; // 0 cpu, 1 dbg

    logic        e_cg, e_dg;
    logic [73:0] exp_vec, obs_vec;

    stpu_irom_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (cpu_req_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_gnt_o   (cpu_gnt_o),
        .cpu_rvalid_o(cpu_rvalid_o),
        .cpu_rdata_o (cpu_rdata_o),
        .dbg_req_i   (dbg_req_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_gnt_o   (dbg_gnt_o),
        .dbg_rvalid_o(dbg_rvalid_o),
        .dbg_rdata_o (dbg_rdata_o),
        .rom_ce_o    (rom_ce_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_spo)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM with clock enable
    always @(posedge clk) begin
        if (rom_ce_o) rom_spo <= rom_mem[rom_addr_o];
    end

    task automatic model_reset();
        m_pend        = 0;
        m_pend_addr   = '0;
        m_last_addr   = '0;
        m_cpu_word    = '0;
        m_dbg_word    = '0;
        m_denied      = 0;
        m_last_winner = 1;
    endtask

    // Drives one cycle, samples the DUT, computes expectations and advances the model.
    task automatic drive_cycle(input logic rn, input logic cr, input logic [ADDR_W-1:0] ca,
                               input logic dr, input logic [ADDR_W-1:0] da);
        logic [ADDR_W-1:0] e_addr;
        logic              e_crv, e_drv;
        logic [DATA_W-1:0] e_crd, e_drd;
        @(negedge clk);
        rst = rn; cpu_req_i = cr; cpu_addr_i = ca; dbg_req_i = dr; dbg_addr_i = da;
        #1;
        cyc++;
        if (!rn) model_reset();
        if (!rn) begin
            e_cg = 1'b0; e_dg = 1'b0;
        end else if (cr && dr) begin
`ifdef STPU_IROM_ARB_RR_EN
            e_dg = (m_last_winner == 0);
`else
            e_dg = (m_denied >= STARVE_MAX);
`endif
            e_cg = !e_dg;
        end else begin
            e_cg = cr; e_dg = dr;
        end
        e_addr = e_cg ? ca : (e_dg ? da : m_last_addr);
        e_crv  = (m_pend == 1);
        e_drv  = (m_pend == 2);
        e_crd  = e_crv ? rom_mem[m_pend_addr] : m_cpu_word;
        e_drd  = e_drv ? rom_mem[m_pend_addr] : m_dbg_word;
        exp_vec = {e_cg, e_dg, e_cg | e_dg, e_addr, e_crv, e_crd, e_drv, e_drd};
        obs_vec = {cpu_gnt_o, dbg_gnt_o, rom_ce_o, rom_addr_o, cpu_rvalid_o, cpu_rdata_o,
                   dbg_rvalid_o, dbg_rdata_o};
        if (rn) begin
            if (e_crv) m_cpu_word = rom_mem[m_pend_addr];
            if (e_drv) m_dbg_word = rom_mem[m_pend_addr];
            m_pend      = e_cg ? 1 : (e_dg ? 2 : 0);
            m_pend_addr = e_addr;
            if (e_cg || e_dg) m_last_addr = e_addr;
            if (e_cg) m_last_winner = 0;
            else if (e_dg) m_last_winner = 1;
            if (dr && !e_dg) m_denied = (m_denied < 255) ? m_denied + 1 : 255;
            else m_denied = 0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));
            n_checks++;
            if (obs_vec !== 74'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got=%h want=0", cyc, obs_vec);
            end
        end
    endtask

    task automatic test_cpu_fetch();
        int rv_count = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive_cycle(1'b1, 1'b1, 5'(i), 1'b0, 5'd0);
            else       drive_cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
            if (cpu_rvalid_o) rv_count++;
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL cpu_fetch cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (rv_count !== 3) begin
            n_fail++;
            $display("FAIL cpu_fetch_rvalid_count got=%0d want=3", rv_count);
        end
    endtask

    task automatic test_dbg_read();
        drive_cycle(1'b1, 1'b0, 5'd0, 1'b1, 5'd5);
        n_checks++;
        if (obs_vec !== exp_vec || dbg_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL dbg_issue cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL dbg_return cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (dbg_rdata_o !== rom_mem[5]) begin
            n_fail++;
            $display("FAIL dbg_rdata_hold got=%h want=%h", dbg_rdata_o, rom_mem[5]);
        end
    endtask

    task automatic test_contention();
        logic [ADDR_W-1:0] ca, da;
        int first_dbg = 0;
        int cpu_wins  = 0;
        int want_first, want_cpu;
`ifdef STPU_IROM_ARB_RR_EN
        want_first = 2;  want_cpu = 16;
`else
        want_first = STARVE_MAX + 1;  want_cpu = 32 - 2;
`endif
        drive_cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        ca = 5'($urandom); da = 5'($urandom);
        for (int i = 1; i <= 32; i++) begin
            drive_cycle(1'b1, 1'b1, ca, 1'b1, da);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL contention cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            if (dbg_gnt_o && first_dbg == 0) first_dbg = i;
            if (cpu_gnt_o) cpu_wins++;
            if (e_cg) ca = 5'($urandom);
            if (e_dg) da = 5'($urandom);
        end
        n_checks++;
        if (first_dbg !== want_first) begin
            n_fail++;
            $display("FAIL contention_first_dbg got=%0d want=%0d", first_dbg, want_first);
        end
        n_checks++;
        if (cpu_wins !== want_cpu) begin
            n_fail++;
            $display("FAIL contention_cpu_grants got=%0d want=%0d", cpu_wins, want_cpu);
        end
    endtask

    task automatic test_reset_inflight();
        drive_cycle(1'b1, 1'b1, 5'd7, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
            n_checks++;
            if (obs_vec !== 74'd0) begin
                n_fail++;
                $display("FAIL reset_inflight_outputs cyc=%0d got=%h want=0", cyc, obs_vec);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
            n_checks++;
            if (obs_vec !== exp_vec || cpu_rvalid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_inflight_release cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_idle_hold();
        drive_cycle(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, 5'($urandom), 1'b0, 5'($urandom));
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL idle_hold cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (rom_addr_o !== 5'd3 || rom_ce_o !== 1'b0 || cpu_rdata_o !== rom_mem[3]) begin
            n_fail++;
            $display("FAIL idle_hold_final addr=%0d ce=%b data=%h want addr=3 ce=0 data=%h",
                     rom_addr_o, rom_ce_o, cpu_rdata_o, rom_mem[3]);
        end
    endtask

    task automatic test_random();
        logic              cr = 1'b0, dr = 1'b0, rn;
        logic [ADDR_W-1:0] ca = '0, da = '0;
        for (int i = 0; i < 400; i++) begin
            if (!cr) begin cr = ($urandom_range(0, 3) != 0); ca = 5'($urandom); end
            if (!dr) begin dr = ($urandom_range(0, 2) == 0); da = 5'($urandom); end
            rn = ($urandom_range(0, 63) != 0);
            drive_cycle(rn, cr, ca, dr, da);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            if (e_cg) cr = 1'b0;
            if (e_dg) dr = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = $urandom;
        model_reset();
        test_reset();
        test_cpu_fetch();
        test_dbg_read();
        test_contention();
        test_reset_inflight();
        test_idle_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
